// File: rtl/adc_frame_reader.sv
// Serial 14-bit ADC reader that frames samples into lines and frames from a single START.
// Define ADC_TEST_PATTERN_EN to add TEST_MODE, which replaces samples with a {LINE_Y, PIX_X} ramp.
`ifndef ADC_WIDHT
`define ADC_WIDHT 14
`endif

module adc_frame_reader #(
  parameter int PIX_PER_LINE = 384,
  parameter int LINES        = 288,
  parameter int CLK_DIV      = 2,
  parameter int CONV_CYCLES  = 20,
  parameter int XW           = (PIX_PER_LINE > 1) ? $clog2(PIX_PER_LINE) : 1,
  parameter int YW           = (LINES > 1) ? $clog2(LINES) : 1
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   START,
`ifdef ADC_TEST_PATTERN_EN
  input  logic                   TEST_MODE,
`endif
  output logic                   BUSY,
  output logic                   ADC_CNV,
  output logic                   ADC_SCLK,
  input  logic                   ADC_SDO,
  output logic [`ADC_WIDHT-1:0]  OUT_ADC,
  output logic                   ENABLE,
  output logic                   LINE_FIRST,
  output logic                   FRAME_DONE,
  output logic [XW-1:0]          PIX_X,
  output logic [YW-1:0]          LINE_Y
);

  localparam int W   = `ADC_WIDHT;
  localparam int CNW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam int DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CONV  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_OUT   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]     state;
  logic [CNW-1:0] conv_cnt;
  logic [DW-1:0]  div_cnt;
  logic [3:0]     bit_cnt;
  logic           sclk;
  logic [W-1:0]   shreg;
  logic [W-1:0]   sample;
  logic           last_col;
  logic           last_pix;

  assign last_col = (PIX_X == XW'(PIX_PER_LINE - 1));
  assign last_pix = last_col && (LINE_Y == YW'(LINES - 1));

`ifdef ADC_TEST_PATTERN_EN
  logic [XW+YW-1:0] ramp;
  assign ramp = {LINE_Y, PIX_X};
  always_comb begin
    sample = shreg;
    if (TEST_MODE) sample = W'(ramp);
  end
`else
  assign sample = shreg;
`endif

  assign BUSY       = (state != S_IDLE);
  assign ADC_CNV    = (state == S_CONV);
  assign ADC_SCLK   = sclk;
  assign ENABLE     = (state == S_OUT);
  assign LINE_FIRST = ENABLE && (PIX_X == '0);
  assign FRAME_DONE = (state == S_DONE);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= S_IDLE;
      conv_cnt <= '0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      sclk     <= 1'b0;
      shreg    <= '0;
      OUT_ADC  <= '0;
      PIX_X    <= '0;
      LINE_Y   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            state    <= S_CONV;
            conv_cnt <= '0;
            PIX_X    <= '0;
            LINE_Y   <= '0;
          end
        end
        S_CONV: begin
          if (conv_cnt == CNW'(CONV_CYCLES - 1)) begin
            state    <= S_SHIFT;
            conv_cnt <= '0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            sclk     <= 1'b0;
          end else begin
            conv_cnt <= conv_cnt + 1'b1;
          end
        end
        S_SHIFT: begin
          // Each half-period ends on a toggle; rising toggles capture SDO, the last falling one exits.
          if (div_cnt == DW'(CLK_DIV - 1)) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
            if (!sclk) begin
              shreg <= {shreg[W-2:0], ADC_SDO};
            end else if (bit_cnt == 4'(W - 1)) begin
              state   <= S_OUT;
              OUT_ADC <= sample;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_OUT: begin
          if (last_pix) begin
            state <= S_DONE;
          end else begin
            state    <= S_CONV;
            conv_cnt <= '0;
            if (last_col) begin
              PIX_X  <= '0;
              LINE_Y <= LINE_Y + 1'b1;
            end else begin
              PIX_X <= PIX_X + 1'b1;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_frame_reader.sv
// Bench for adc_frame_reader: random ADC words from a pin-level ADC model, scoreboarded per frame.
`ifndef ADC_WIDHT
`define ADC_WIDHT 14
`endif

module tb_adc_frame_reader;
  localparam int P    = 4;
  localparam int L    = 3;
  localparam int DIV  = 2;
  localparam int CONV = 3;
  localparam int W    = `ADC_WIDHT;
  localparam int XW   = 2;
  localparam int YW   = 2;
  localparam int NPIX = P * L;
  localparam int LAT  = CONV + 2 * DIV * W + 1;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  logic START = 1'b0;
  logic ADC_SDO;
`ifdef ADC_TEST_PATTERN_EN
  logic TEST_MODE = 1'b0;
`endif
  logic BUSY, ADC_CNV, ADC_SCLK, ENABLE, LINE_FIRST, FRAME_DONE;
  logic [W-1:0]  OUT_ADC;
  logic [XW-1:0] PIX_X;
  logic [YW-1:0] LINE_Y;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  adc_frame_reader #(
    .PIX_PER_LINE(P),
    .LINES(L),
    .CLK_DIV(DIV),
    .CONV_CYCLES(CONV)
  ) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .START(START),
`ifdef ADC_TEST_PATTERN_EN
    .TEST_MODE(TEST_MODE),
`endif
    .BUSY(BUSY),
    .ADC_CNV(ADC_CNV),
    .ADC_SCLK(ADC_SCLK),
    .ADC_SDO(ADC_SDO),
    .OUT_ADC(OUT_ADC),
    .ENABLE(ENABLE),
    .LINE_FIRST(LINE_FIRST),
    .FRAME_DONE(FRAME_DONE),
    .PIX_X(PIX_X),
    .LINE_Y(LINE_Y)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  // ADC model: new random word per conversion, MSB first, next bit after each SCLK fall.
  logic [W-1:0] adc_word = '0;
  int bit_idx = W;
  logic [W-1:0] exp_q[$];
  always @(posedge ADC_CNV) begin
    adc_word = W'($urandom);
    exp_q.push_back(adc_word);
    bit_idx = 0;
  end
  always @(negedge ADC_SCLK) if (bit_idx < W) bit_idx++;
  assign ADC_SDO = (bit_idx < W) ? adc_word[W-1-bit_idx] : 1'b0;

  logic [W-1:0] s_adc[$];
  int s_x[$], s_y[$], s_lf[$], s_cyc[$];
  int done_cnt, done_cyc, cnv_hi, sclk_hi, sclk_rise, lf_stray;
  logic sclk_prev = 1'b0;

  always @(negedge CLK) begin
    if (ENABLE === 1'b1) begin
      s_adc.push_back(OUT_ADC);
      s_x.push_back(int'(PIX_X));
      s_y.push_back(int'(LINE_Y));
      s_lf.push_back(int'(LINE_FIRST));
      s_cyc.push_back(cyc);
    end
    if (LINE_FIRST === 1'b1 && ENABLE !== 1'b1) lf_stray++;
    if (FRAME_DONE === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (ADC_CNV === 1'b1) cnv_hi++;
    if (ADC_SCLK === 1'b1) begin
      sclk_hi++;
      if (!sclk_prev) sclk_rise++;
    end
    sclk_prev = (ADC_SCLK === 1'b1);
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic clear_mon();
    s_adc.delete(); s_x.delete(); s_y.delete(); s_lf.delete(); s_cyc.delete();
    exp_q.delete();
    done_cnt = 0; done_cyc = 0; cnv_hi = 0; sclk_hi = 0; sclk_rise = 0; lf_stray = 0;
  endtask

  task automatic start_frame(output int c);
    tick();
    START = 1'b1;
    c = cyc;
    tick();
    START = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [23:0] outs;
    int bad;
    RESET_N = 1'b0;
    repeat (3) tick();
    outs = {BUSY, ADC_CNV, ADC_SCLK, ENABLE, LINE_FIRST, FRAME_DONE, OUT_ADC, PIX_X, LINE_Y};
    total++;
    if (outs !== '0) $display("FAIL reset_outputs: got %h required 0", outs);
    else passed++;
    RESET_N = 1'b1;
    bad = 0;
    repeat (100) begin
      tick();
      outs = {BUSY, ADC_CNV, ADC_SCLK, ENABLE, LINE_FIRST, FRAME_DONE, OUT_ADC, PIX_X, LINE_Y};
      if (outs !== '0) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL idle_outputs: %0d nonzero cycles, required 0", bad);
    else passed++;
  endtask

  task automatic test_frame(input bit pattern);
    int c, x, y, n, last;
    bit ok;
    logic [W-1:0] e;
    clear_mon();
    start_frame(c);
    wait_done(LAT * NPIX + 100, ok);
    total++;
    if (!ok) $display("FAIL frame_timeout: done_cnt=%0d required 1", done_cnt);
    else passed++;
    total++;
    if (s_adc.size() != NPIX) $display("FAIL strobe_count: got %0d required %0d", s_adc.size(), NPIX);
    else passed++;
    n = (s_adc.size() < NPIX) ? s_adc.size() : NPIX;
    for (int i = 0; i < n; i++) begin
      x = i % P;
      y = i / P;
      if (pattern) e = W'((y << XW) | x);
      else e = (i < exp_q.size()) ? exp_q[i] : 'x;
      total++;
      if (s_adc[i] !== e) $display("FAIL out_adc[%0d]: got %h required %h", i, s_adc[i], e);
      else passed++;
      total++;
      if (s_x[i] != x || s_y[i] != y)
        $display("FAIL index[%0d]: got x=%0d y=%0d required x=%0d y=%0d", i, s_x[i], s_y[i], x, y);
      else passed++;
      total++;
      if (s_lf[i] != int'(x == 0)) $display("FAIL line_first[%0d]: got %0d required %0d", i, s_lf[i], int'(x == 0));
      else passed++;
    end
    if (n > 0) begin
      last = s_cyc[n-1];
      total++;
      if (s_cyc[0] - c != LAT) $display("FAIL first_latency: got %0d required %0d", s_cyc[0] - c, LAT);
      else passed++;
      total++;
      if (last - s_cyc[0] != (n - 1) * LAT)
        $display("FAIL pixel_period: got %0d required %0d", last - s_cyc[0], (n - 1) * LAT);
      else passed++;
      total++;
      if (done_cyc != last + 1) $display("FAIL done_timing: got %0d required %0d", done_cyc, last + 1);
      else passed++;
    end
    total++;
    if (cnv_hi != CONV * NPIX) $display("FAIL cnv_cycles: got %0d required %0d", cnv_hi, CONV * NPIX);
    else passed++;
    total++;
    if (sclk_rise != W * NPIX || sclk_hi != DIV * W * NPIX)
      $display("FAIL sclk: got rises=%0d high=%0d required %0d %0d", sclk_rise, sclk_hi, W * NPIX, DIV * W * NPIX);
    else passed++;
    total++;
    if (lf_stray != 0) $display("FAIL lf_stray: got %0d required 0", lf_stray);
    else passed++;
    tick();
    total++;
    if (BUSY !== 1'b0 || ADC_SCLK !== 1'b0) $display("FAIL busy_after_done: got busy=%b sclk=%b required 0 0", BUSY, ADC_SCLK);
    else passed++;
    repeat (20) tick();
    total++;
    if (done_cnt != 1) $display("FAIL done_count: got %0d required 1", done_cnt);
    else passed++;
  endtask

  task automatic test_start_while_busy();
    int c;
    bit ok;
    clear_mon();
    start_frame(c);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (ADC_SCLK === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) $display("FAIL shift_timeout: sclk never high, required high");
    else passed++;
    START = 1'b1;
    tick();
    START = 1'b0;
    wait_done(LAT * NPIX + 100, ok);
    START = 1'b1;
    tick();
    START = 1'b0;
    repeat (2 * LAT) tick();
    total++;
    if (s_adc.size() != NPIX || done_cnt != 1)
      $display("FAIL start_while_busy: got strobes=%0d dones=%0d required %0d 1", s_adc.size(), done_cnt, NPIX);
    else passed++;
    total++;
    if (BUSY !== 1'b0) $display("FAIL busy_idle: got %b required 0", BUSY);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int c;
    bit ok;
    clear_mon();
    start_frame(c);
    wait_done(LAT * NPIX + 100, ok);
    tick();
    total++;
    if (BUSY !== 1'b0) $display("FAIL first_idle_busy: got %b required 0", BUSY);
    else passed++;
    clear_mon();
    START = 1'b1;
    c = cyc;
    tick();
    START = 1'b0;
    total++;
    if (BUSY !== 1'b1 || ADC_CNV !== 1'b1)
      $display("FAIL b2b_accept: got busy=%b cnv=%b required 1 1", BUSY, ADC_CNV);
    else passed++;
    wait_done(LAT * NPIX + 100, ok);
    total++;
    if (!ok || s_adc.size() != NPIX)
      $display("FAIL b2b_frame: got done=%0d strobes=%0d required 1 %0d", ok, s_adc.size(), NPIX);
    else passed++;
    if (s_cyc.size() > 0) begin
      total++;
      if (s_cyc[0] - c != LAT) $display("FAIL b2b_latency: got %0d required %0d", s_cyc[0] - c, LAT);
      else passed++;
    end
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    int c, n;
    bit ok;
    logic [23:0] outs;
    clear_mon();
    start_frame(c);
    ok = 1'b0;
    for (int i = 0; i < 4 * LAT; i++) begin
      tick();
      if (s_adc.size() == 2 && ADC_SCLK === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) $display("FAIL mid_timeout: strobes=%0d required 2 with sclk high", s_adc.size());
    else passed++;
    RESET_N = 1'b0;
    #1;
    outs = {BUSY, ADC_CNV, ADC_SCLK, ENABLE, LINE_FIRST, FRAME_DONE, OUT_ADC, PIX_X, LINE_Y};
    total++;
    if (outs !== '0) $display("FAIL async_reset: got %h required 0", outs);
    else passed++;
    tick();
    RESET_N = 1'b1;
    n = s_adc.size();
    repeat (150) tick();
    total++;
    if (s_adc.size() != n || BUSY !== 1'b0)
      $display("FAIL no_resume: got strobes=%0d busy=%b required %0d 0", s_adc.size(), BUSY, n);
    else passed++;
    clear_mon();
    start_frame(c);
    ok = 1'b0;
    for (int i = 0; i < 2 * LAT; i++) begin
      tick();
      if (s_adc.size() > 0) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) $display("FAIL restart_timeout: no strobe, required 1");
    else passed++;
    if (ok) begin
      total++;
      if (s_x[0] != 0 || s_y[0] != 0 || s_cyc[0] - c != LAT || exp_q.size() == 0 || s_adc[0] !== exp_q[0])
        $display("FAIL restart_first: got x=%0d y=%0d lat=%0d adc=%h required 0 0 %0d %h",
                 s_x[0], s_y[0], s_cyc[0] - c, s_adc[0], LAT, (exp_q.size() > 0) ? exp_q[0] : '0);
      else passed++;
    end
    wait_done(LAT * NPIX + 100, ok);
    total++;
    if (!ok || s_adc.size() != NPIX)
      $display("FAIL restart_frame: got done=%0d strobes=%0d required 1 %0d", ok, s_adc.size(), NPIX);
    else passed++;
    repeat (3) tick();
  endtask

`ifdef ADC_TEST_PATTERN_EN
  task automatic test_pattern();
    TEST_MODE = 1'b1;
    test_frame(1'b1);
    TEST_MODE = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_frame(1'b0);
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
`ifdef ADC_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
